// File: rtl/taco_order_if.sv
// Byte-in / order-out handshake bundle for the taco-code order decoder.
//   in_data   ASCII order byte (source -> decoder)
//   in_valid  in_data is valid (source -> decoder)
//   in_ready  decoder accepts a byte this cycle (decoder -> source)
//   out_sel   one-hot taco type of the current order (decoder -> consumer)
//   out_qty   order quantity 1..9 (decoder -> consumer)
//   out_valid order presented on out_sel/out_qty (decoder -> consumer)
//   out_ready consumer accepts the order (consumer -> decoder)
// Modport slave is the decoder's view; master is the surrounding source/consumer.
interface taco_order_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_sel;
   logic [3:0] out_qty;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_sel,
      output out_qty,
      output out_valid,
      input  out_ready
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_sel,
      input  out_qty,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/taco_order_decoder.sv
// Taco order decoder: turns a stream of ASCII order bytes ("[1-9]?[CPFD]") into a
// one-hot taco select plus quantity, and keeps saturating per-type quantity tallies.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      taco_order_if.slave: byte stream in, order stream out
//   err      one-cycle pulse per rejected (malformed) byte
//   tally_c/p/f/d  accepted quantity totals for chicharron/papa/frijol/deshebrada
// One-hot select: C=0001, P=0010, F=0100, D=1000.
module taco_order_decoder #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   taco_order_if.slave      bus,
   output logic             err,
   output logic [CNT_W-1:0] tally_c,
   output logic [CNT_W-1:0] tally_p,
   output logic [CNT_W-1:0] tally_f,
   output logic [CNT_W-1:0] tally_d
);

   localparam int unsigned SumW = CNT_W + 5;

   typedef enum logic [1:0] {
      StIdle,
      StQty,
      StOut
   } state_e;

   state_e     state_q;
   logic [3:0] out_sel_q;
   logic [3:0] out_qty_q;
   logic       out_valid_q;
   logic [3:0] qty_q;
   logic       err_q;

   logic [3:0] byte_sel;
   logic       byte_letter;
   logic       byte_digit;
   logic       byte_blank;

   // Saturating accumulate of one order quantity into a tally.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] tally,
                                                input logic [3:0] qty);
      logic [SumW-1:0] sum;
      logic [SumW-1:0] max_val;
      sum     = SumW'(tally) + SumW'(qty);
      max_val = SumW'({CNT_W{1'b1}});
      if (sum > max_val) begin
         return {CNT_W{1'b1}};
      end
      return sum[CNT_W-1:0];
   endfunction

   // Classify the incoming byte.
   always_comb begin
      byte_sel = 4'b0000;
      case (bus.in_data)
         8'd67:   byte_sel = 4'b0001;
         8'd80:   byte_sel = 4'b0010;
         8'd70:   byte_sel = 4'b0100;
         8'd68:   byte_sel = 4'b1000;
         default: byte_sel = 4'b0000;
      endcase
      byte_letter = |byte_sel;
      byte_digit  = (bus.in_data >= 8'd49) && (bus.in_data <= 8'd57);
      byte_blank  = (bus.in_data == 8'd32) || (bus.in_data == 8'd10);
   end

   // Backpressure the byte source while an order is waiting.
   assign bus.in_ready  = (state_q != StOut);
   assign bus.out_sel   = out_sel_q;
   assign bus.out_qty   = out_qty_q;
   assign bus.out_valid = out_valid_q;
   assign err           = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         out_sel_q   <= 4'b0000;
         out_qty_q   <= 4'd0;
         out_valid_q <= 1'b0;
         qty_q       <= 4'd0;
         err_q       <= 1'b0;
         tally_c     <= '0;
         tally_p     <= '0;
         tally_f     <= '0;
         tally_d     <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  if (byte_letter) begin
                     out_sel_q   <= byte_sel;
                     out_qty_q   <= 4'd1;
                     out_valid_q <= 1'b1;
                     state_q     <= StOut;
                  end else if (byte_digit) begin
                     // '1'..'9' are 0x31..0x39, so the low nibble is the quantity.
                     qty_q   <= bus.in_data[3:0];
                     state_q <= StQty;
                  end else if (!byte_blank) begin
                     err_q <= 1'b1;
                  end
               end
            end
            StQty: begin
               if (bus.in_valid) begin
                  if (byte_letter) begin
                     out_sel_q   <= byte_sel;
                     out_qty_q   <= qty_q;
                     out_valid_q <= 1'b1;
                     state_q     <= StOut;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StIdle;
                  end
                  qty_q <= 4'd0;
               end
            end
            StOut: begin
               if (bus.out_ready) begin
                  unique case (out_sel_q)
                     4'b0001: tally_c <= sat_add(tally_c, out_qty_q);
                     4'b0010: tally_p <= sat_add(tally_p, out_qty_q);
                     4'b0100: tally_f <= sat_add(tally_f, out_qty_q);
                     4'b1000: tally_d <= sat_add(tally_d, out_qty_q);
                     default: ;
                  endcase
                  out_sel_q   <= 4'b0000;
                  out_qty_q   <= 4'd0;
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
